// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates the game work-RAM port between the CPU and the hiscore engine: pauses the CPU,
// waits for its ack plus SETTLE cycles, then serves single engine accesses until release.
module hiscore_ram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int SETTLE  = 4,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              hs_req,
    input  logic              hs_strobe,
    input  logic              hs_we,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [DATA_W-1:0] hs_wdata,
    output logic              hs_grant,
    output logic              hs_ack,
    output logic [DATA_W-1:0] hs_rdata,
    output logic              hs_timeout,
    output logic              cpu_pause_req,
    input  logic              cpu_pause_ack,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // One counter serves the pause timeout, the settle delay and the read latency.
    localparam int CNT_W = $clog2(TIMEOUT + 256);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_SETTLE,
        S_GRANT,
        S_READ,
        S_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_timeout;
    logic                r_req_d;

    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_set_timeout;
    logic                w_wr_ack;
    logic                w_rd_start;
    logic                w_rd_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_set_timeout = 1'b0;
        w_wr_ack      = 1'b0;
        w_rd_start    = 1'b0;
        w_rd_done     = 1'b0;
        hs_grant      = 1'b0;
        cpu_pause_req = 1'b0;
        ram_addr      = cpu_addr;
        ram_we        = cpu_we;
        ram_wdata     = cpu_wdata;

        unique case (r_state)
            S_IDLE: begin
                if (hs_req) begin
                    w_next    = S_PAUSE;
                    w_cnt_clr = 1'b1;
                end
            end
            S_PAUSE: begin
                cpu_pause_req = 1'b1;
                if (!hs_req) begin
                    w_next = S_RELEASE;
                end else if (cpu_pause_ack) begin
                    w_next    = S_SETTLE;
                    w_cnt_clr = 1'b1;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next        = S_RELEASE;
                    w_set_timeout = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_SETTLE: begin
                cpu_pause_req = 1'b1;
                ram_we        = 1'b0;
                if (!hs_req) begin
                    w_next = S_RELEASE;
                end else if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_next = S_GRANT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_GRANT: begin
                cpu_pause_req = 1'b1;
                hs_grant      = 1'b1;
                ram_addr      = hs_addr;
                ram_wdata     = hs_wdata;
                ram_we        = hs_strobe & hs_we;
                if (hs_strobe && hs_we) begin
                    w_wr_ack = 1'b1;
                end else if (hs_strobe) begin
                    w_next     = S_READ;
                    w_rd_start = 1'b1;
                    w_cnt_clr  = 1'b1;
                end else if (!hs_req) begin
                    w_next = S_RELEASE;
                end
            end
            S_READ: begin
                cpu_pause_req = 1'b1;
                hs_grant      = 1'b1;
                ram_addr      = r_addr;
                ram_wdata     = hs_wdata;
                ram_we        = 1'b0;
                if (r_cnt == CNT_W'(RD_LAT - 1)) begin
                    w_next    = S_GRANT;
                    w_rd_done = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_RELEASE: begin
                ram_we = 1'b0;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_timeout <= 1'b0;
            r_req_d   <= 1'b0;
        end else begin
            r_req_d <= hs_req;
            r_ack   <= w_wr_ack | w_rd_done;
            if (w_cnt_clr)                      r_cnt <= '0;
            else if (w_cnt_inc && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
            if (w_rd_start) r_addr  <= hs_addr;
            if (w_rd_done)  r_rdata <= ram_rdata;
            // Only a fresh request clears the flag, so it survives a held hs_req retrying.
            if (hs_req && !r_req_d) r_timeout <= 1'b0;
            else if (w_set_timeout) r_timeout <= 1'b1;
        end
    end

    assign hs_ack     = r_ack;
    assign hs_rdata   = r_rdata;
    assign hs_timeout = r_timeout;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Scoreboard bench for hiscore_ram_arbiter: engine accesses are modelled against a shadow
// memory, expected acks are queued with their due cycle and checked by a separate monitor.
module tb_hiscore_ram_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int SETTLE  = 4;
    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 4095;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b1;
    logic              hs_req = 1'b0, hs_strobe = 1'b0, hs_we = 1'b0;
    logic [ADDR_W-1:0] hs_addr = '0;
    logic [DATA_W-1:0] hs_wdata = '0;
    logic              hs_grant, hs_ack, hs_timeout, cpu_pause_req;
    logic [DATA_W-1:0] hs_rdata;
    logic              cpu_pause_ack = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = 16'h4321;
    logic              cpu_we = 1'b0;
    logic [DATA_W-1:0] cpu_wdata = 8'h00;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    hiscore_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(SETTLE), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .hs_req(hs_req), .hs_strobe(hs_strobe), .hs_we(hs_we),
        .hs_addr(hs_addr), .hs_wdata(hs_wdata),
        .hs_grant(hs_grant), .hs_ack(hs_ack), .hs_rdata(hs_rdata), .hs_timeout(hs_timeout),
        .cpu_pause_req(cpu_pause_req), .cpu_pause_ack(cpu_pause_ack),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk_sys) cyc++;

    // Single-port RAM with one cycle of read latency.
    logic [DATA_W-1:0] mem [0:65535];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: what the engine should see, independent of the arbiter's internals.
    typedef struct {
        bit          is_rd;
        logic [7:0]  data;
        int          due;
    } exp_t;
    exp_t       exp_q[$];
    logic [7:0] model_mem [int];
    logic [7:0] last_rd = 8'h00;
    int         busy_until = 0;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Issue one engine access in the current cycle and record what the model expects.
    task automatic issue(input bit we, input logic [15:0] a, input logic [7:0] d);
        hs_strobe = 1'b1;
        hs_we     = we;
        hs_addr   = a;
        hs_wdata  = d;
        if (cyc >= busy_until) begin
            if (we) begin
                model_mem[int'(a)] = d;
                exp_q.push_back('{is_rd: 1'b0, data: 8'h00, due: cyc + 1});
            end else begin
                exp_q.push_back('{is_rd: 1'b1, data: model_read(a), due: cyc + RD_LAT + 1});
                busy_until = cyc + RD_LAT + 1;
            end
        end
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 50 && !hs_grant; i++) tick();
        @(negedge clk_sys);
        check("grant_wait", hs_grant, 1);
    endtask

    // Monitor: every ack must match the oldest expected access, at its due cycle.
    always @(negedge clk_sys) begin
        if (hs_ack) begin
            if (exp_q.size() == 0) begin
                check("spurious_ack", hs_ack, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_cycle", cyc, e.due);
                if (e.is_rd) begin
                    check("rdata", hs_rdata, e.data);
                    last_rd = e.data;
                end else begin
                    check("rdata_hold_wr", hs_rdata, last_rd);
                end
            end
        end else begin
            check("rdata_hold", hs_rdata, last_rd);
            if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                void'(exp_q.pop_front());
                check("ack_missing", hs_ack, 1);
            end
        end
    end

    initial begin
        int  n_pause;
        bit  early_to;

        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        mem[16'h8011] = 8'hC3;
        model_mem[32'h8011] = 8'hC3;

        // Reset values and CPU passthrough.
        #2 reset_n = 1'b0;
        #1;
        check("rst_grant", hs_grant, 0);
        check("rst_ack", hs_ack, 0);
        check("rst_rdata", hs_rdata, 0);
        check("rst_timeout", hs_timeout, 0);
        check("rst_pause", cpu_pause_req, 0);
        check("rst_ram_addr", ram_addr, 16'h4321);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Strobe outside a session is ignored (monitor flags any ack).
        issue(1'b1, 16'h8000, 8'hEE);
        exp_q.delete();
        tick();
        hs_strobe = 1'b0;
        repeat (2) tick();

        // Pause, ack three cycles later, grant after the settle period.
        hs_req = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            @(negedge clk_sys);
            check("pause_wait_req", cpu_pause_req, 1);
            check("pause_wait_grant", hs_grant, 0);
        end
        tick();
        cpu_pause_ack = 1'b1;
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h77;
        for (int j = 0; j <= SETTLE + 1; j++) begin
            if (j > 0) tick();
            @(negedge clk_sys);
            check("settle_grant", hs_grant, (j == SETTLE + 1));
            check("settle_pause", cpu_pause_req, 1);
            check("settle_ram_we", ram_we, (j == 0));
        end

        // Directed write, then directed read with a latched address.
        tick();
        issue(1'b1, 16'h8010, 8'h5A);
        @(negedge clk_sys);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 16'h8010);
        check("wr_ram_wdata", ram_wdata, 8'h5A);
        tick();
        hs_strobe = 1'b0;
        @(negedge clk_sys);
        check("wr_ram_we_off", ram_we, 0);
        tick();
        issue(1'b0, 16'h8011, 8'h00);
        @(negedge clk_sys);
        check("rd_ram_addr", ram_addr, 16'h8011);
        tick();
        hs_strobe = 1'b0;
        hs_addr = 16'h0000;
        @(negedge clk_sys);
        check("rd_latched_addr", ram_addr, 16'h8011);
        check("rd_ram_we", ram_we, 0);
        tick();

        // Random traffic: strobes during READ are ignored, CPU writes and ack drops must not leak.
        for (int i = 0; i < 120; i++) begin
            tick();
            cpu_pause_ack = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'h8000 | 16'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            if ($urandom_range(0, 1) == 1)
                issue(1'($urandom_range(0, 1)), 16'h8000 | 16'($urandom_range(0, 15)), 8'($urandom));
            else begin
                hs_strobe = 1'b0;
                hs_addr   = 16'($urandom);
            end
            @(negedge clk_sys);
            check("rand_grant", hs_grant, 1);
        end
        tick();
        hs_strobe = 1'b0;
        cpu_we = 1'b0;
        repeat (RD_LAT + 2) tick();

        // Release with a simultaneous write: the strobe wins, then the port returns.
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h77;
        hs_req = 1'b0;
        issue(1'b1, 16'h8005, 8'h3C);
        tick();
        hs_strobe = 1'b0;
        @(negedge clk_sys);
        check("rel_strobe_wins", hs_grant, 1);
        tick();
        @(negedge clk_sys);
        check("rel_grant", hs_grant, 0);
        check("rel_pause", cpu_pause_req, 0);
        check("rel_ram_we", ram_we, 0);
        tick();
        @(negedge clk_sys);
        check("idle_ram_we", ram_we, 1);
        check("idle_ram_addr", ram_addr, 16'h1234);
        check("idle_ram_wdata", ram_wdata, 8'h77);
        tick();
        cpu_we = 1'b0;
        cpu_pause_ack = 1'b0;

        // hs_req dropped during settle: no grant, release, CPU writes reach RAM again.
        tick();
        hs_req = 1'b1;
        tick();
        cpu_pause_ack = 1'b1;
        tick();
        @(negedge clk_sys);
        check("s5_settle_grant", hs_grant, 0);
        tick();
        hs_req = 1'b0;
        cpu_we = 1'b1; cpu_addr = 16'h1235; cpu_wdata = 8'h99;
        @(negedge clk_sys);
        check("s5_settle_we", ram_we, 0);
        check("s5_settle_pause", cpu_pause_req, 1);
        tick();
        @(negedge clk_sys);
        check("s5_rel_grant", hs_grant, 0);
        check("s5_rel_pause", cpu_pause_req, 0);
        check("s5_rel_we", ram_we, 0);
        tick();
        @(negedge clk_sys);
        check("s5_idle_we", ram_we, 1);
        check("s5_idle_addr", ram_addr, 16'h1235);
        tick();
        cpu_we = 1'b0;
        cpu_pause_ack = 1'b0;
        tick();
        check("s5_cpu_write", mem[16'h1235], 8'h99);

        // Pause ack never arrives: timeout after TIMEOUT pause cycles, sticky flag.
        hs_req = 1'b1;
        n_pause = 0;
        early_to = 1'b0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            tick();
            @(negedge clk_sys);
            if (cpu_pause_req) begin
                n_pause++;
                if (hs_timeout) early_to = 1'b1;
            end else if (n_pause > 0) begin
                break;
            end
        end
        check("to_cycles", n_pause, TIMEOUT);
        check("to_early", early_to, 0);
        check("to_flag", hs_timeout, 1);
        check("to_pause_drop", cpu_pause_req, 0);
        tick();
        hs_req = 1'b0;
        repeat (3) tick();
        @(negedge clk_sys);
        check("to_sticky", hs_timeout, 1);
        check("to_idle_pause", cpu_pause_req, 0);
        tick();
        hs_req = 1'b1;
        cpu_pause_ack = 1'b1;
        @(negedge clk_sys);
        check("to_hold_until_edge", hs_timeout, 1);
        tick();
        @(negedge clk_sys);
        check("to_cleared", hs_timeout, 0);
        wait_grant();

        // Reset in the middle of a read: everything returns at once, no ack.
        tick();
        hs_strobe = 1'b1; hs_we = 1'b0; hs_addr = 16'h8010;
        tick();
        hs_strobe = 1'b0;
        #2;
        reset_n = 1'b0;
        last_rd = 8'h00;
        #1;
        check("mid_rst_grant", hs_grant, 0);
        check("mid_rst_pause", cpu_pause_req, 0);
        check("mid_rst_ack", hs_ack, 0);
        check("mid_rst_rdata", hs_rdata, 0);
        check("mid_rst_addr", ram_addr, cpu_addr);
        hs_req = 1'b0;
        cpu_pause_ack = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        @(negedge clk_sys);
        check("post_rst_grant", hs_grant, 0);
        check("post_rst_pause", cpu_pause_req, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
